// File: rtl/spi_sector_sequencer.sv
// SPI sector read sequencer: polls the card for the start token, streams
// BLOCK_LEN data bytes to a ready/valid consumer while running CRC16-CCITT,
// then fetches and checks the two CRC bytes. One byte-shifter transaction is
// outstanding at most; the shifter always transmits 0xFF.
module spi_sector_sequencer #(
  parameter int BLOCK_LEN     = 512,
  parameter int TOKEN_TIMEOUT = 1024
) (
  input  logic       cck,
  input  logic       _reset,
  input  logic       start,
  input  logic       abort,
  output logic       shift_start,
  output logic [7:0] shift_tx,
  input  logic       shift_done,
  input  logic [7:0] shift_rx,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       err_timeout,
  output logic       err_token,
  output logic       err_crc
);

  localparam int BW = $clog2(BLOCK_LEN) + 1;
  localparam int PW = $clog2(TOKEN_TIMEOUT) + 1;
  localparam logic [7:0] TOK_IDLE  = 8'hFF;
  localparam logic [7:0] TOK_START = 8'hFE;

  typedef enum logic [2:0] {
    IDLE,
    POLL,
    DATA,
    CRC_HI,
    CRC_LO,
    FINISH
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            pending;
  logic [BW-1:0]   byte_cnt;
  logic [PW-1:0]   poll_cnt;
  logic [15:0]     crc;
  logic [7:0]      crc_hi;
  logic            rx_take;
  logic            accept;
  logic            last_byte;
  logic            last_poll;

  // CRC16-CCITT (poly 0x1021), MSB first, one byte per call.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // A received byte counts only if we asked for it and the transfer is not
  // being cancelled; stale completions after abort/reset fall out here.
  assign rx_take   = shift_done & pending & ~abort;
  assign accept    = out_valid & out_ready;
  assign last_byte = (byte_cnt == BW'(BLOCK_LEN - 1));
  assign last_poll = (poll_cnt == PW'(TOKEN_TIMEOUT - 1));
  assign shift_tx  = 8'hFF;
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH) & ~abort;

  // State register.
  always_ff @(posedge cck or negedge _reset) begin
    if (!_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and shifter request decode.
  always_comb begin
    state_nxt   = state;
    shift_start = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) state_nxt = POLL;
      end
      POLL: begin
        shift_start = !pending;
        if (rx_take) begin
          if (shift_rx == TOK_START)     state_nxt = DATA;
          else if (shift_rx == TOK_IDLE) begin
            if (last_poll) state_nxt = FINISH;
          end
          else                           state_nxt = FINISH;
        end
      end
      DATA: begin
        shift_start = !pending && !out_valid;
        if (accept && last_byte) state_nxt = CRC_HI;
      end
      CRC_HI: begin
        shift_start = !pending;
        if (rx_take) state_nxt = CRC_LO;
      end
      CRC_LO: begin
        shift_start = !pending;
        if (rx_take) state_nxt = FINISH;
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_nxt   = IDLE;
      shift_start = 1'b0;
    end
  end

  // Byte tracking, output holding register, counters, CRC and error flags.
  always_ff @(posedge cck or negedge _reset) begin
    if (!_reset) begin
      pending     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      byte_cnt    <= '0;
      poll_cnt    <= '0;
      crc         <= 16'h0000;
      crc_hi      <= 8'h00;
      err_timeout <= 1'b0;
      err_token   <= 1'b0;
      err_crc     <= 1'b0;
    end else if (abort) begin
      pending   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (shift_start)     pending <= 1'b1;
      else if (shift_done) pending <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err_timeout <= 1'b0;
            err_token   <= 1'b0;
            err_crc     <= 1'b0;
            crc         <= 16'h0000;
            byte_cnt    <= '0;
            poll_cnt    <= '0;
          end
        end
        POLL: begin
          if (rx_take) begin
            if (shift_rx == TOK_IDLE) begin
              poll_cnt <= poll_cnt + PW'(1);
              if (last_poll) err_timeout <= 1'b1;
            end else if (shift_rx != TOK_START) begin
              err_token <= 1'b1;
            end
          end
        end
        DATA: begin
          if (rx_take) begin
            out_data  <= shift_rx;
            out_valid <= 1'b1;
          end
          if (accept) begin
            out_valid <= 1'b0;
            crc       <= crc16_byte(crc, out_data);
            byte_cnt  <= byte_cnt + BW'(1);
          end
        end
        CRC_HI: begin
          if (rx_take) crc_hi <= shift_rx;
        end
        CRC_LO: begin
          if (rx_take && ({crc_hi, shift_rx} != crc)) err_crc <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
